// File: rtl/exu_ctrl_if.sv
// rtl/exu_ctrl_if.sv - IFU/LSU valid/ready handshake bundle for the exu sequencer
interface exu_ctrl_if;
    logic if_req_valid;
    logic if_req_ready;
    logic if_rsp_valid;
    logic if_rsp_ready;
    logic lsu_req_valid;
    logic lsu_req_we;
    logic lsu_req_ready;
    logic lsu_rsp_valid;

    modport master (
        output if_req_valid, if_rsp_ready, lsu_req_valid, lsu_req_we,
        input  if_req_ready, if_rsp_valid, lsu_req_ready, lsu_rsp_valid
    );

    modport slave (
        input  if_req_valid, if_rsp_ready, lsu_req_valid, lsu_req_we,
        output if_req_ready, if_rsp_valid, lsu_req_ready, lsu_rsp_valid
    );
endinterface

// File: rtl/exu_ctrl.sv
// rtl/exu_ctrl.sv - multi-cycle fetch/exec/mem/wb sequencer with handshake timeout
module exu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    exu_ctrl_if.master  bus,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_branch,
    input  logic        dec_jump,
    input  logic        dec_ebreak,
    input  logic        dec_rd_wen,
    input  logic        branch_cond,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        rf_wen,
    output logic        rf_wdata_sel,
    output logic        halt,
    output logic        err,
    output logic [31:0] retire_cnt
);
    localparam logic [2:0] S_FETCH      = 3'd0;
    localparam logic [2:0] S_FETCH_WAIT = 3'd1;
    localparam logic [2:0] S_EXEC       = 3'd2;
    localparam logic [2:0] S_MEM        = 3'd3;
    localparam logic [2:0] S_MEM_WAIT   = 3'd4;
    localparam logic [2:0] S_WB         = 3'd5;
    localparam logic [2:0] S_HALT       = 3'd6;
    localparam logic [2:0] S_ERROR      = 3'd7;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] tmo_cnt;
    logic       tmo_hit;
    logic       live;
    logic       in_wb;

    // The current wait cycle is number tmo_cnt+1; a response in it still wins.
    assign tmo_hit = (tmo_cnt + 8'd1) == TMO_LIMIT;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:      if (bus.if_req_ready) state_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (bus.if_rsp_valid)  state_nxt = S_EXEC;
                else if (tmo_hit)      state_nxt = S_ERROR;
            end
            S_EXEC: begin
                if (dec_ebreak)                  state_nxt = S_HALT;
                else if (dec_load || dec_store)  state_nxt = S_MEM;
                else                             state_nxt = S_WB;
            end
            S_MEM:        if (bus.lsu_req_ready) state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (bus.lsu_rsp_valid) state_nxt = S_WB;
                else if (tmo_hit)      state_nxt = S_ERROR;
            end
            S_WB:         state_nxt = S_FETCH;
            default:      state_nxt = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            tmo_cnt    <= 8'd0;
            retire_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            // Request states precede every wait state, so clearing there clears on entry.
            if (state == S_FETCH || state == S_MEM)
                tmo_cnt <= 8'd0;
            else if ((state == S_FETCH_WAIT && !bus.if_rsp_valid) ||
                     (state == S_MEM_WAIT && !bus.lsu_rsp_valid))
                tmo_cnt <= tmo_cnt + 8'd1;
            retire_cnt <= retire_cnt + {31'd0, state == S_WB};
        end
    end

    // Everything is held low while rst is asserted, whatever the registered state.
    assign live  = ~rst;
    assign in_wb = live & (state == S_WB);

    assign bus.if_req_valid  = live & (state == S_FETCH);
    assign bus.if_rsp_ready  = live & (state == S_FETCH_WAIT);
    assign bus.lsu_req_valid = live & (state == S_MEM);
    assign bus.lsu_req_we    = live & (state == S_MEM) & dec_store;

    assign ir_en        = live & (state == S_FETCH_WAIT) & bus.if_rsp_valid;
    assign pc_en        = in_wb;
    assign pc_sel       = in_wb & (dec_jump | (dec_branch & branch_cond));
    assign rf_wen       = in_wb & dec_rd_wen & ~dec_store & ~dec_branch;
    assign rf_wdata_sel = in_wb & dec_load;
    assign halt         = live & (state == S_HALT);
    assign err          = live & (state == S_ERROR);
endmodule

// File: tb/tb_exu_ctrl.sv
// tb/tb_exu_ctrl.sv - directed self-checking bench for exu_ctrl
module tb_exu_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic dec_load, dec_store, dec_branch, dec_jump, dec_ebreak, dec_rd_wen, branch_cond;
    logic ir_en, pc_en, pc_sel, rf_wen, rf_wdata_sel, halt, err;
    logic [31:0] retire_cnt;
    int ncheck = 0;
    int npass  = 0;

    exu_ctrl_if bus ();

    exu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .dec_load(dec_load), .dec_store(dec_store), .dec_branch(dec_branch),
        .dec_jump(dec_jump), .dec_ebreak(dec_ebreak), .dec_rd_wen(dec_rd_wen),
        .branch_cond(branch_cond),
        .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .rf_wen(rf_wen),
        .rf_wdata_sel(rf_wdata_sel), .halt(halt), .err(err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.if_req_ready = 1'b0; bus.if_rsp_valid = 1'b0;
        bus.lsu_req_ready = 1'b0; bus.lsu_rsp_valid = 1'b0;
        dec_load = 1'b0; dec_store = 1'b0; dec_branch = 1'b0; dec_jump = 1'b0;
        dec_ebreak = 1'b0; dec_rd_wen = 1'b0; branch_cond = 1'b0;
    endtask

    task automatic set_dec(input logic ld, st, br, jp, wen, cond);
        dec_load = ld; dec_store = st; dec_branch = br; dec_jump = jp;
        dec_ebreak = 1'b0; dec_rd_wen = wen; branch_cond = cond;
    endtask

    // Leaves the bench in the first post-reset cycle (FETCH, rst low).
    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Drives handshakes on given cycle numbers (1 = FETCH cycle) and captures the WB cycle.
    task automatic run_sched(input int c_ifr, input int c_ifs, input int c_lr, input int c_ls,
                             output int wb_at, output int lv_cnt, output logic we_at,
                             output logic sel_at, output logic wen_at, output logic wds_at);
        wb_at = 0; lv_cnt = 0; we_at = 1'b0; sel_at = 1'b0; wen_at = 1'b0; wds_at = 1'b0;
        for (int c = 1; c <= 30 && wb_at == 0; c++) begin
            bus.if_req_ready  = (c == c_ifr);
            bus.if_rsp_valid  = (c == c_ifs);
            bus.lsu_req_ready = (c == c_lr);
            bus.lsu_rsp_valid = (c == c_ls);
            #1;
            if (bus.lsu_req_valid) begin
                lv_cnt++;
                we_at = bus.lsu_req_we;
            end
            if (pc_en) begin
                wb_at = c; sel_at = pc_sel; wen_at = rf_wen; wds_at = rf_wdata_sel;
            end
            step();
        end
        bus.if_req_ready = 1'b0; bus.if_rsp_valid = 1'b0;
        bus.lsu_req_ready = 1'b0; bus.lsu_rsp_valid = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        ncheck++; if (bus.if_req_valid !== 1'b0) $display("FAIL reset_if_req_valid got %b exp 0", bus.if_req_valid); else npass++;
        ncheck++; if ({pc_en, ir_en, rf_wen, halt, err} !== 5'b0) $display("FAIL reset_strobes got %b exp 00000", {pc_en, ir_en, rf_wen, halt, err}); else npass++;
        ncheck++; if (retire_cnt !== 32'd0) $display("FAIL reset_retire got %0d exp 0", retire_cnt); else npass++;
        rst = 1'b0;
        #1;
        ncheck++; if (bus.if_req_valid !== 1'b1) $display("FAIL reset_first_fetch got %b exp 1", bus.if_req_valid); else npass++;
    endtask

    task automatic test_addi;
        int wb; int lv; logic we, sel, wen, wds;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.if_req_ready = 1'b1;
        #1;
        ncheck++; if (ir_en !== 1'b0) $display("FAIL addi_ir_en_c1 got %b exp 0", ir_en); else npass++;
        step();
        bus.if_req_ready = 1'b0; bus.if_rsp_valid = 1'b1;
        #1;
        ncheck++; if ({ir_en, bus.if_rsp_ready} !== 2'b11) $display("FAIL addi_ir_en_c2 got %b exp 11", {ir_en, bus.if_rsp_ready}); else npass++;
        step();
        bus.if_rsp_valid = 1'b0;
        #1;
        ncheck++; if ({pc_en, ir_en, rf_wen} !== 3'b000) $display("FAIL addi_exec_quiet got %b exp 000", {pc_en, ir_en, rf_wen}); else npass++;
        step();
        #1;
        ncheck++; if ({pc_en, rf_wen, pc_sel, rf_wdata_sel} !== 4'b1100) $display("FAIL addi_wb got %b exp 1100", {pc_en, rf_wen, pc_sel, rf_wdata_sel}); else npass++;
        step();
        ncheck++; if (retire_cnt !== 32'd1) $display("FAIL addi_retire got %0d exp 1", retire_cnt); else npass++;
        ncheck++; if (bus.if_req_valid !== 1'b1) $display("FAIL addi_next_fetch got %b exp 1", bus.if_req_valid); else npass++;
        // Second zero-wait ALU op back to back: WB must land on cycle 4 again.
        run_sched(1, 2, 0, 0, wb, lv, we, sel, wen, wds);
        ncheck++; if (wb !== 4) $display("FAIL addi2_wb_cycle got %0d exp 4", wb); else npass++;
    endtask

    task automatic test_load;
        int wb; int lv; logic we, sel, wen, wds;
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_sched(1, 2, 7, 10, wb, lv, we, sel, wen, wds);
        ncheck++; if (lv !== 4) $display("FAIL lw_req_valid_cycles got %0d exp 4", lv); else npass++;
        ncheck++; if (we !== 1'b0) $display("FAIL lw_we got %b exp 0", we); else npass++;
        ncheck++; if (wb !== 11) $display("FAIL lw_wb_cycle got %0d exp 11", wb); else npass++;
        ncheck++; if ({wen, wds, sel} !== 3'b110) $display("FAIL lw_wb_ctrl got %b exp 110", {wen, wds, sel}); else npass++;
        ncheck++; if (retire_cnt !== 32'd3) $display("FAIL lw_retire got %0d exp 3", retire_cnt); else npass++;
    endtask

    task automatic test_branch_store;
        int wb; int lv; logic we, sel, wen, wds;
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        run_sched(1, 2, 0, 0, wb, lv, we, sel, wen, wds);
        ncheck++; if ({sel, wen} !== 2'b10) $display("FAIL beq_taken got %b exp 10", {sel, wen}); else npass++;
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_sched(1, 2, 0, 0, wb, lv, we, sel, wen, wds);
        ncheck++; if ({sel, wen} !== 2'b00) $display("FAIL bne_not_taken got %b exp 00", {sel, wen}); else npass++;
        set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_sched(1, 2, 4, 5, wb, lv, we, sel, wen, wds);
        ncheck++; if ({we, wen, wds} !== 3'b100) $display("FAIL sw_ctrl got %b exp 100", {we, wen, wds}); else npass++;
        ncheck++; if (wb !== 6) $display("FAIL sw_wb_cycle got %0d exp 6", wb); else npass++;
        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_sched(1, 2, 0, 0, wb, lv, we, sel, wen, wds);
        ncheck++; if ({sel, wen} !== 2'b11) $display("FAIL jal_ctrl got %b exp 11", {sel, wen}); else npass++;
        ncheck++; if (retire_cnt !== 32'd7) $display("FAIL bs_retire got %0d exp 7", retire_cnt); else npass++;
    endtask

    task automatic test_ebreak;
        int act = 0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dec_ebreak = 1'b1;
        bus.if_req_ready = 1'b1;
        step();
        bus.if_req_ready = 1'b0; bus.if_rsp_valid = 1'b1;
        step();
        bus.if_rsp_valid = 1'b0;
        #1;
        ncheck++; if (halt !== 1'b0) $display("FAIL ebreak_exec_halt got %b exp 0", halt); else npass++;
        step();
        ncheck++; if (halt !== 1'b1) $display("FAIL ebreak_halt got %b exp 1", halt); else npass++;
        bus.if_req_ready = 1'b1; bus.if_rsp_valid = 1'b1;
        bus.lsu_req_ready = 1'b1; bus.lsu_rsp_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.if_req_valid | bus.lsu_req_valid | bus.if_rsp_ready | pc_en | ir_en | rf_wen | !halt) act++;
            step();
        end
        ncheck++; if (act !== 0) $display("FAIL ebreak_quiet got %0d active cycles exp 0", act); else npass++;
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        ncheck++; if ({halt, bus.if_req_valid} !== 2'b01) $display("FAIL ebreak_rst got %b exp 01", {halt, bus.if_req_valid}); else npass++;
        ncheck++; if (retire_cnt !== 32'd0) $display("FAIL ebreak_rst_retire got %0d exp 0", retire_cnt); else npass++;
    endtask

    task automatic test_timeout;
        int errs_early = 0;
        do_reset();
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.if_req_ready = 1'b1;
        step();
        bus.if_req_ready = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            #1;
            if (err !== 1'b0 || bus.if_rsp_ready !== 1'b1) errs_early++;
            step();
        end
        ncheck++; if (errs_early !== 0) $display("FAIL tmo_early got %0d bad wait cycles exp 0", errs_early); else npass++;
        ncheck++; if ({err, bus.if_req_valid, bus.if_rsp_ready} !== 3'b100) $display("FAIL tmo_error got %b exp 100", {err, bus.if_req_valid, bus.if_rsp_ready}); else npass++;
        bus.if_rsp_valid = 1'b1; bus.if_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        ncheck++; if ({err, ir_en} !== 2'b10) $display("FAIL tmo_sticky got %b exp 10", {err, ir_en}); else npass++;
        do_reset();
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ncheck++; if (err !== 1'b0) $display("FAIL tmo_rst_clear got %b exp 0", err); else npass++;
        bus.if_req_ready = 1'b1;
        step();
        bus.if_req_ready = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            bus.if_rsp_valid = (w == 4);
            step();
        end
        bus.if_rsp_valid = 1'b0;
        #1;
        ncheck++; if ({err, pc_en} !== 2'b00) $display("FAIL tmo_boundary_exec got %b exp 00", {err, pc_en}); else npass++;
        step();
        ncheck++; if ({err, pc_en} !== 2'b01) $display("FAIL tmo_boundary_wb got %b exp 01", {err, pc_en}); else npass++;
        step();
    endtask

    task automatic test_wrap;
        int wb; int lv; logic we, sel, wen, wds;
        do_reset();
        force dut.retire_cnt = 32'hFFFF_FFFF;
        bus.lsu_rsp_valid = 1'b1;
        step();
        release dut.retire_cnt;
        bus.lsu_rsp_valid = 1'b0;
        #1;
        ncheck++; if ({bus.if_req_valid, bus.if_rsp_ready, bus.lsu_req_valid} !== 3'b100) $display("FAIL stray_rsp got %b exp 100", {bus.if_req_valid, bus.if_rsp_ready, bus.lsu_req_valid}); else npass++;
        ncheck++; if (retire_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_preload got %h exp ffffffff", retire_cnt); else npass++;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_sched(1, 2, 0, 0, wb, lv, we, sel, wen, wds);
        ncheck++; if (retire_cnt !== 32'd0) $display("FAIL wrap_retire got %h exp 00000000", retire_cnt); else npass++;
        ncheck++; if (wb !== 4) $display("FAIL wrap_wb_cycle got %0d exp 4", wb); else npass++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_branch_store();
        test_ebreak();
        test_timeout();
        test_wrap();
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
